pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter WIDTH, default 16, sets the width of the PC, the addresses and the instruction word.
REQ-002 Parameter OFFSET_WIDTH, default 9, sets the width of the branch offset.
REQ-003 Parameter STEP, default 2, is the sequential PC increment.
REQ-004 Parameter RESET_VECTOR, default 0, is the PC value loaded on reset.
REQ-005 Ports SHALL be:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- imem_resp  in  1  memory read complete.
- imem_rdata  in  WIDTH  instruction data, valid with imem_resp.
- advance  in  1  decode consumed ir; fetch the next sequential instruction.
- redirect_valid  in  1  control-flow change this cycle.
- redirect_sel  in  2  target source: 0 branch, 1 register, 2 trap, 3 reserved.
- offset  in  OFFSET_WIDTH  signed branch offset, in words.
- reg_target  in  WIDTH  register jump target.
- trapvect  in  8  trap vector number.
- imem_read  out  1  memory read request.
- imem_address  out  WIDTH  read address.
- pc  out  WIDTH  current PC.
- pc_plus_step  out  WIDTH  pc + STEP.
- ir  out  WIDTH  held instruction.
- ir_valid  out  1  ir holds the instruction at pc.

Function
REQ-006 State machine states SHALL be IDLE, FETCH and HOLD.
REQ-007 IDLE SHALL go to FETCH unconditionally on the next clock.
REQ-008 In FETCH, imem_read SHALL be 1 and imem_address SHALL equal pc; imem_read SHALL stay high until imem_resp.
REQ-009 In IDLE and HOLD, imem_read SHALL be 0.
REQ-010 On FETCH with imem_resp and no pending redirect, ir SHALL latch imem_rdata and the state SHALL go to HOLD.
REQ-011 ir_valid SHALL be 1 only in HOLD.
REQ-012 pc_plus_step SHALL be combinational pc + STEP, modulo 2^WIDTH.
REQ-013 Redirect targets SHALL be:
- branch: pc_plus_step + (sign-extended offset << 1), modulo 2^WIDTH.
- register: reg_target with bit 0 forced to 0.
- trap: zero-extended trapvect << 1.
REQ-014 redirect_sel 3 SHALL be ignored: no PC change and no pending redirect.
REQ-015 In HOLD, redirect_valid SHALL load pc with the target and go to FETCH; redirect_valid SHALL take priority over a simultaneous advance.
REQ-016 In HOLD, advance without redirect_valid SHALL load pc with pc_plus_step and go to FETCH.
REQ-017 In HOLD with neither input, pc and ir SHALL hold.
REQ-018 In FETCH without imem_resp, redirect_valid SHALL store the target in a pending register and set a pending flag; imem_read SHALL stay high.
REQ-019 A later redirect SHALL overwrite the earlier pending target (latest wins).
REQ-020 In FETCH with imem_resp and the pending flag set, imem_rdata SHALL be discarded; pc SHALL load the pending target, the flag SHALL clear, and the state SHALL stay FETCH.
REQ-021 In FETCH with imem_resp and redirect_valid in the same cycle, imem_rdata SHALL be discarded; pc SHALL load the new target, which overrides any pending target, and the state SHALL stay FETCH.
REQ-022 advance SHALL be ignored outside HOLD.
REQ-023 PC wrap-around SHALL be silent, with no error flag.

Reset
REQ-024 Asserting reset SHALL immediately, without waiting for clk, set:
- state to IDLE.
- pc to RESET_VECTOR.
- ir to 0, ir_valid to 0.
- pending flag to 0, pending target to 0.
- imem_read to 0.
REQ-025 Reset during FETCH SHALL abandon the outstanding request.
REQ-026 After reset, any imem_resp that arrives before the next imem_read SHALL be ignored.

Verification
REQ-027 Reset release with imem_resp immediate, imem_rdata=0x1234 -> imem_read rises one cycle after release at address 0x0000, ir=0x1234, ir_valid=1.
REQ-028 HOLD at pc=0x0010 with advance -> next FETCH at imem_address=0x0012.
REQ-029 HOLD at pc=0x0010, branch offset=0x1FF (-1) with advance also high -> pc=0x0010; the redirect wins over advance.
REQ-030 FETCH at pc=0x3000 with a trap redirect trapvect=0x25 two cycles before imem_resp -> data discarded, then refetch at 0x004A.
REQ-031 pc=0xFFFE with advance -> pc=0x0000; register redirect reg_target=0x4001 -> pc=0x4000.
REQ-032 Reset asserted mid-FETCH -> imem_read drops immediately and pc=RESET_VECTOR.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch sequencer: issues reads at pc, holds the
// returned instruction for decode, and applies branch/register/trap redirects.
module pc_fetch_unit #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned OFFSET_WIDTH = 9,
    parameter int unsigned STEP         = 2,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    imem_resp,
    input  logic [WIDTH-1:0]        imem_rdata,
    input  logic                    advance,
    input  logic                    redirect_valid,
    input  logic [1:0]              redirect_sel,
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  logic [WIDTH-1:0]        reg_target,
    input  logic [7:0]              trapvect,
    output logic                    imem_read,
    output logic [WIDTH-1:0]        imem_address,
    output logic [WIDTH-1:0]        pc,
    output logic [WIDTH-1:0]        pc_plus_step,
    output logic [WIDTH-1:0]        ir,
    output logic                    ir_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_d;

    logic [WIDTH-1:0]        pc_q, pc_d;
    logic [WIDTH-1:0]        ir_q, ir_d;
    logic [WIDTH-1:0]        pend_tgt_q, pend_tgt_d;
    logic                    pend_q, pend_d;
    logic [WIDTH-1:0]        target;
    logic                    redirect_ok;
    logic signed [WIDTH-1:0] off_ext;

    assign pc_plus_step = pc_q + WIDTH'(STEP);
    assign off_ext      = WIDTH'($signed(offset));
    assign imem_address = pc_q;
    assign pc           = pc_q;
    assign ir           = ir_q;

    // Redirect target selection; selector 3 is treated as no redirect at all.
    always_comb begin
        target      = '0;
        redirect_ok = redirect_valid;
        case (redirect_sel)
            2'd0:    target = pc_plus_step + {off_ext[WIDTH-2:0], 1'b0};
            2'd1:    target = {reg_target[WIDTH-1:1], 1'b0};
            2'd2:    target = WIDTH'({trapvect, 1'b0});
            default: redirect_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc_q       <= WIDTH'(RESET_VECTOR);
            ir_q       <= '0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state      <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = pc_q;
        ir_d       = ir_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        imem_read  = 1'b0;
        ir_valid   = 1'b0;
        case (state)
            IDLE: state_d = FETCH;
            FETCH: begin
                imem_read = 1'b1;
                // A redirect seen while the read is in flight makes its data stale.
                if (imem_resp) begin
                    if (redirect_ok) begin
                        pc_d   = target;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_d   = pend_tgt_q;
                        pend_d = 1'b0;
                    end else begin
                        ir_d    = imem_rdata;
                        state_d = HOLD;
                    end
                end else if (redirect_ok) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = target;
                end
            end
            HOLD: begin
                ir_valid = 1'b1;
                if (redirect_ok) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (advance) begin
                    pc_d    = pc_plus_step;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised and directed checks of pc_fetch_unit against a transaction-level
// model of fetch, hold and redirect behaviour.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        advance;
    logic        redirect_valid;
    logic [1:0]  redirect_sel;
    logic [8:0]  offset;
    logic [15:0] reg_target;
    logic [7:0]  trapvect;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] pc;
    logic [15:0] pc_plus_step;
    logic [15:0] ir;
    logic        ir_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Model: phase 0 = waiting to start, 1 = read outstanding, 2 = instruction held.
    int m_phase, m_pc, m_ir, m_pend, m_ptgt;

    pc_fetch_unit #(
        .WIDTH(16), .OFFSET_WIDTH(9), .STEP(2), .RESET_VECTOR(0)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .advance(advance), .redirect_valid(redirect_valid),
        .redirect_sel(redirect_sel), .offset(offset),
        .reg_target(reg_target), .trapvect(trapvect),
        .imem_read(imem_read), .imem_address(imem_address),
        .pc(pc), .pc_plus_step(pc_plus_step),
        .ir(ir), .ir_valid(ir_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_target(int sel, int off, int rt, int tv, int cur);
        int soff;
        soff = (off >= 256) ? off - 512 : off;
        case (sel)
            0:       return (cur + 2 + 2 * soff) & 'hFFFF;
            1:       return rt & 'hFFFE;
            default: return (tv * 2) & 'hFFFF;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pc = 0; m_ir = 0; m_pend = 0; m_ptgt = 0;
    endtask

    task automatic compare_all();
        check("pc", 32'(pc), 32'(m_pc));
        check("pc_plus_step", 32'(pc_plus_step), 32'((m_pc + 2) & 'hFFFF));
        check("imem_read", 32'(imem_read), 32'(m_phase == 1));
        if (m_phase == 1) check("imem_address", 32'(imem_address), 32'(m_pc));
        check("ir_valid", 32'(ir_valid), 32'(m_phase == 2));
        check("ir", 32'(ir), 32'(m_ir));
    endtask

    // Called at a falling edge: apply inputs, advance one clock, update model, check.
    task automatic tick(input logic resp, input logic [15:0] rdata, input logic adv,
                        input logic rv, input logic [1:0] sel, input logic [8:0] off,
                        input logic [15:0] rt, input logic [7:0] tv);
        int tgt;
        bit rok;
        imem_resp = resp; imem_rdata = rdata; advance = adv;
        redirect_valid = rv; redirect_sel = sel; offset = off;
        reg_target = rt; trapvect = tv;
        @(posedge clk);
        rok = rv && (sel != 2'd3);
        tgt = rok ? model_target(int'(sel), int'(off), int'(rt), int'(tv), m_pc) : 0;
        case (m_phase)
            0: m_phase = 1;
            1: begin
                if (resp && rok) begin
                    m_pc = tgt; m_pend = 0;
                end else if (resp && m_pend != 0) begin
                    m_pc = m_ptgt; m_pend = 0;
                end else if (resp) begin
                    m_ir = int'(rdata); m_phase = 2;
                end else if (rok) begin
                    m_pend = 1; m_ptgt = tgt;
                end
            end
            default: begin
                if (rok) begin
                    m_pc = tgt; m_phase = 1;
                end else if (adv) begin
                    m_pc = (m_pc + 2) & 'hFFFF; m_phase = 1;
                end
            end
        endcase
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_tick();
        tick(1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 9'h0, 16'h0, 8'h0);
    endtask

    task automatic jump_reg(input logic resp, input logic [15:0] rt);
        tick(resp, 16'h0, 1'b0, 1'b1, 2'd1, 9'h0, rt, 8'h0);
    endtask

    task automatic accept(input logic [15:0] data);
        tick(1'b1, data, 1'b0, 1'b0, 2'd0, 9'h0, 16'h0, 8'h0);
    endtask

    initial begin
        reset = 1'b1;
        imem_resp = 1'b0; imem_rdata = '0; advance = 1'b0;
        redirect_valid = 1'b0; redirect_sel = '0; offset = '0;
        reg_target = '0; trapvect = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Response while not yet fetching is ignored, then the first fetch completes.
        tick(1'b1, 16'hBEEF, 1'b0, 1'b0, 2'd0, 9'h0, 16'h0, 8'h0);
        check("first_read_addr", 32'(imem_address), 32'h0000);
        accept(16'h1234);
        check("first_ir", 32'(ir), 32'h1234);
        check("first_ir_valid", 32'(ir_valid), 32'h1);

        // Hold at 0x0010, then sequential advance.
        jump_reg(1'b0, 16'h0010);
        accept(16'h1111);
        tick(1'b0, 16'h0, 1'b1, 1'b0, 2'd0, 9'h0, 16'h0, 8'h0);
        check("advance_addr", 32'(imem_address), 32'h0012);

        // Redirect on the completing cycle drops data; branch -1 beats advance.
        jump_reg(1'b1, 16'h0010);
        accept(16'h2222);
        tick(1'b0, 16'h0, 1'b1, 1'b1, 2'd0, 9'h1FF, 16'h0, 8'h0);
        check("branch_over_adv", 32'(pc), 32'h0010);

        // Pending trap redirect two cycles before the response.
        jump_reg(1'b1, 16'h3000);
        tick(1'b0, 16'h0, 1'b0, 1'b1, 2'd2, 9'h0, 16'h0, 8'h25);
        idle_tick();
        tick(1'b1, 16'hDEAD, 1'b0, 1'b0, 2'd0, 9'h0, 16'h0, 8'h0);
        check("trap_refetch", 32'(imem_address), 32'h004A);
        check("trap_discard", 32'(ir), 32'h2222);

        // Reserved selector while a redirect is pending must not disturb it.
        tick(1'b0, 16'h0, 1'b0, 1'b1, 2'd1, 9'h0, 16'h0100, 8'h0);
        tick(1'b0, 16'h0, 1'b0, 1'b1, 2'd3, 9'h0, 16'h0200, 8'h0);
        accept(16'h3333);
        check("pending_kept", 32'(pc), 32'h0100);

        // Wrap-around and register alignment.
        jump_reg(1'b1, 16'hFFFE);
        accept(16'h4444);
        tick(1'b0, 16'h0, 1'b1, 1'b0, 2'd0, 9'h0, 16'h0, 8'h0);
        check("pc_wrap", 32'(pc), 32'h0000);
        accept(16'h5555);
        jump_reg(1'b0, 16'h4001);
        check("reg_align", 32'(pc), 32'h4000);

        // Asynchronous reset while a read is outstanding.
        #2 reset = 1'b1;
        #1;
        check("rst_imem_read", 32'(imem_read), 32'h0);
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_ir_valid", 32'(ir_valid), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        compare_all();

        for (int i = 0; i < 400; i++) begin
            tick(1'(($urandom % 10) < 4), 16'($urandom), 1'($urandom % 2),
                 1'(($urandom % 4) == 0), 2'($urandom), 9'($urandom),
                 16'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
